wb_queue: RTL
=============

# wb_queue

Write-back queue between the execute/memory stages and the register file write port. Accepts results from the single-cycle ALU path and the multi-cycle load path over valid/ready handshakes and buffers them in a small FIFO. Drains one entry per cycle onto the register file's `RegWrite`/`write_reg`/`write_data` port. Publishes a per-register pending mask for decode stall logic and, optionally, forwards queued values onto the operand read path.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU result accepted this edge when high with `alu_valid`.
- `alu_reg`  in  3  ALU destination register.
- `alu_data`  in  16  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  load result accepted this edge when high with `mem_valid`.
- `mem_reg`  in  3  load destination register.
- `mem_data`  in  16  load data.
- `hold`  in  1  when high, the queue does not drain this cycle.
- `RegWrite`  out  1  write enable to the register file.
- `write_reg`  out  3  register file write address.
- `write_data`  out  16  register file write data.
- `read_reg_1`, `read_reg_2`  in  3 each  decode operand addresses, also driven to the register file.
- `read_data_1_in`, `read_data_2_in`  in  16 each  register file read data.
- `fwd_data_1`, `fwd_data_2`  out  16 each  operand values delivered to execute.
- `pending`  out  8  bit i high while any queued entry targets register i.
- `empty`, `full`  out  1 each  FIFO status.

## Operation
- Storage: `DEPTH` entries of {reg[2:0], data[15:0]}, with write pointer, read pointer and count (width log2(DEPTH)+1). Pointers wrap modulo `DEPTH`.
- Arbitration is fixed priority, load over ALU, with at most one enqueue per cycle.
  - `mem_ready` = !full.
  - `alu_ready` = !full && !mem_valid.
- A handshake whose destination is r0 completes normally but is not enqueued. Count is unchanged and `pending` is unaffected.
- Dequeue occurs when !empty && !hold.
  - `RegWrite` = !empty && !hold.
  - `write_reg`/`write_data` = head entry when !empty, else 0.
  - The register file writes at the same edge the entry is popped.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at any occupancy below full.
- Full with `hold` high: both readies are low, so no accept occurs. The producers stall.
- `pending`: OR over valid entries of the one-hot destination. Bit 0 is always 0. The mask is combinational from FIFO state.
- Reset, asserted at any time: pointers and count go to 0 and all queued writes are discarded.
  - `RegWrite`=0, `write_reg`=0, `write_data`=0.
  - `pending`=0, `empty`=1, `full`=0.
  - `alu_ready`=1 unless `mem_valid` is high; `mem_ready`=1.
  - `fwd_data_k` = `read_data_k_in`.

## Timing
- Enqueue at edge N. `RegWrite` is high in the following cycle (absent `hold`), and the register file is updated at edge N+1. Minimum latency is one cycle.
- Throughput is one accept and one drain per cycle.
- Readies are combinational from `full` and `mem_valid`, with no dependency on `alu_valid`.
- `pending` rises the cycle after acceptance. It falls the cycle after the last matching entry pops.
- All forwarding and pending paths are combinational within the cycle.

## Configuration
- `WB_BYPASS_EN` defined: `fwd_data_k` is the data of the youngest valid entry whose reg equals `read_reg_k`, including the head entry being written this cycle.
  - Falls back to `read_data_k_in` when there is no match or when `read_reg_k`=0.
  - Youngest means the entry closest to the write pointer.
- `WB_BYPASS_EN` undefined: `fwd_data_k` = `read_data_k_in` unconditionally. Decode must stall on `pending`.

## Test plan
- Reset with `rst_n`=0 mid-stream, holding 3 entries → `empty`=1, `pending`=8'h00, `RegWrite`=0. No write reaches the register file after release.
- ALU writes r3=16'h1234 with `hold`=0 → `RegWrite`=1, `write_reg`=3, `write_data`=16'h1234 in the next cycle. `pending[3]` pulses for one cycle.
- Both valid in the same cycle (mem r2=16'hAAAA, alu r5=16'h5555) → load accepted first and `alu_ready`=0. The ALU entry is accepted the next cycle, and the drain order is r2 then r5.
- `hold`=1 with 4 ALU writes (DEPTH=4) → `full`=1 and `alu_ready`=`mem_ready`=0. Release `hold` → four in-order writes on consecutive cycles, then `empty`=1.
- Write to r0 with data 16'hFFFF → handshake completes, `empty` stays 1, `RegWrite` never asserts.
- With `WB_BYPASS_EN` and `hold`=1: queue r4=16'h0001 then r4=16'h0002, `read_reg_1`=4, `read_data_1_in`=16'h0000 → `fwd_data_1`=16'h0002. Without the macro → 16'h0000 and `pending[4]`=1.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: write-back queue between execute/memory and the register file write port.
// ALU and load results are buffered in a small FIFO. The FIFO drains one entry per
// cycle into the register file. A per-register pending mask is published for decode.
// Optional macro WB_BYPASS_EN: queued values are forwarded onto the operand read path.
// Without the macro, the read data passes straight through.
module wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [2:0]  alu_reg,
   input  logic [15:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [2:0]  mem_reg,
   input  logic [15:0] mem_data,
   input  logic        hold,
   output logic        RegWrite,
   output logic [2:0]  write_reg,
   output logic [15:0] write_data,
   input  logic [2:0]  read_reg_1,
   input  logic [2:0]  read_reg_2,
   input  logic [15:0] read_data_1_in,
   input  logic [15:0] read_data_2_in,
   output logic [15:0] fwd_data_1,
   output logic [15:0] fwd_data_2,
   output logic [7:0]  pending,
   output logic        empty,
   output logic        full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   // Entry storage carries no reset; occupancy is tracked solely by the pointers/count.
   logic [2:0]    reg_q  [DEPTH];
   logic [15:0]   data_q [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q,  cnt_d;

   logic          acc_mem, acc_alu;
   logic [2:0]    enq_reg;
   logic [15:0]   enq_data;
   logic          push, pop;
   logic [DEPTH-1:0] ent_vld;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));

   // Loads have priority over the ALU. The readies never look at alu_valid.
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;

   // Pick the single accepted producer. r0 writes handshake but are dropped.
   always_comb begin
      acc_mem  = mem_valid && mem_ready;
      acc_alu  = alu_valid && alu_ready;
      enq_reg  = acc_mem ? mem_reg  : alu_reg;
      enq_data = acc_mem ? mem_data : alu_data;
      push     = (acc_mem || acc_alu) && (enq_reg != 3'd0);
      pop      = !empty && !hold;
   end

   // Next pointer and count values. Push and pop together leave the count unchanged.
   always_comb begin
      wptr_d = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state register. Reset discards every queued write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry write at the write pointer on an accepted, non-r0 handshake.
   always_ff @(posedge clk) begin
      if (push) begin
         reg_q[wptr_q]  <= enq_reg;
         data_q[wptr_q] <= enq_data;
      end
   end

   // Head entry drives the register file write port. Outputs are zero when empty.
   always_comb begin
      RegWrite   = pop;
      write_reg  = 3'd0;
      write_data = 16'd0;
      if (!empty) begin
         write_reg  = reg_q[rptr_q];
         write_data = data_q[rptr_q];
      end
   end

   // Slot i is occupied when its distance from the read pointer is below the count.
   always_comb begin
      ent_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_vld[i] = ({1'b0, PW'(i) - rptr_q} < cnt_q);
      end
   end

   // Pending mask: OR of one-hot destinations over occupied slots. r0 is never pending.
   always_comb begin
      pending = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) pending[reg_q[i]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Scan the slots from oldest to youngest so that the youngest match wins.
   // The head entry counts as a match even while it is being written.
   always_comb begin
      fwd_data_1 = read_data_1_in;
      fwd_data_2 = read_data_2_in;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < cnt_q) begin
            if (read_reg_1 != 3'd0 && reg_q[rptr_q + PW'(k)] == read_reg_1)
               fwd_data_1 = data_q[rptr_q + PW'(k)];
            if (read_reg_2 != 3'd0 && reg_q[rptr_q + PW'(k)] == read_reg_2)
               fwd_data_2 = data_q[rptr_q + PW'(k)];
         end
      end
   end
`else
   // No forwarding: decode stalls on pending, and operands come from the register file.
   logic unused_rd_regs;
   assign unused_rd_regs = ^{read_reg_1, read_reg_2};

   // Register file data passes through to execute unchanged.
   always_comb begin
      fwd_data_1 = read_data_1_in;
      fwd_data_2 = read_data_2_in;
   end
`endif

endmodule
